// File: rtl/fetch_stage_pkg.sv
// +--------------------------------------------------------------------+
// | fetch_stage_pkg: exception codes and address map for fetch         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fetch_stage_pkg;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4
    } exc_code_t;

    localparam logic [31:0] RESET_VECTOR   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_VECTOR = 32'h0000_4180;
    localparam logic [31:0] TEXT_LOW       = 32'h0000_3000;
    localparam logic [31:0] TEXT_HIGH      = 32'h0000_6FFC;
    localparam logic [31:0] PC_STEP        = 32'd4;

    // Misaligned or outside the text segment.
    function automatic logic is_addr_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < TEXT_LOW) || (pc > TEXT_HIGH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_addr_check.sv
// +--------------------------------------------------------------------+
// | fetch_addr_check: combinational fetch address fault detection      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_addr_check
    import fetch_stage_pkg::*;
(
    input  logic [31:0] Pc_F,
    output logic        fault,
    output logic [4:0]  Exception_F
);

    always_comb begin
        fault       = is_addr_fault(Pc_F);
        Exception_F = fault ? EXC_ADEL : EXC_INT;
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------+
// | fetch_stage: PC register, next-PC selection and instruction fetch  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        En_F,
    input  logic        req,
    input  logic        eret_D,
    input  logic [31:0] EPC,
    input  logic        Jump_D,
    input  logic [31:0] NPC_D,
    input  logic        IsBJ_D,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] Pc_F,
    output logic [31:0] Instruction_F,
    output logic [4:0]  Exception_F,
    output logic        BD_F,
    output logic [31:0] Fetch_Cnt
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] cnt_q;
    logic        advance;
    logic        fault;

    // req outranks the stall so an exception is never lost while held.
    always_comb begin
        pc_next = pc_q + PC_STEP;
        advance = 1'b0;
        if (req) begin
            pc_next = HANDLER_VECTOR;
        end else if (!En_F) begin
            pc_next = pc_q;
        end else begin
            advance = 1'b1;
            if (eret_D) begin
                pc_next = EPC;
            end else if (Jump_D) begin
                pc_next = NPC_D;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= 32'd0;
        end else begin
            pc_q <= pc_next;
            if (advance) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    fetch_addr_check u_addr_check (
        .Pc_F        (pc_q),
        .fault       (fault),
        .Exception_F (Exception_F)
    );

    assign Pc_F          = pc_q;
    assign i_inst_addr   = pc_q;
    assign Instruction_F = fault ? 32'd0 : i_inst_rdata;
    assign BD_F          = IsBJ_D;
    assign Fetch_Cnt     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: PC sequencing, redirect priority,
// address faults and fetch counting with hand-computed expectations.
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        En_F;
    logic        req;
    logic        eret_D;
    logic [31:0] EPC;
    logic        Jump_D;
    logic [31:0] NPC_D;
    logic        IsBJ_D;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] Pc_F;
    logic [31:0] Instruction_F;
    logic [4:0]  Exception_F;
    logic        BD_F;
    logic [31:0] Fetch_Cnt;

    int passes = 0;
    int total  = 0;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .En_F          (En_F),
        .req           (req),
        .eret_D        (eret_D),
        .EPC           (EPC),
        .Jump_D        (Jump_D),
        .NPC_D         (NPC_D),
        .IsBJ_D        (IsBJ_D),
        .i_inst_addr   (i_inst_addr),
        .i_inst_rdata  (i_inst_rdata),
        .Pc_F          (Pc_F),
        .Instruction_F (Instruction_F),
        .Exception_F   (Exception_F),
        .BD_F          (BD_F),
        .Fetch_Cnt     (Fetch_Cnt)
    );

    // Memory model: data word tags the low half of the address.
    assign i_inst_rdata = {16'hC0DE, i_inst_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full output check for a given expected PC, count and fault status.
    task automatic check_state(input string tag, input logic [31:0] pc,
                               input logic [31:0] cnt, input logic flt);
        check({tag, ".pc"},   Pc_F, pc);
        check({tag, ".addr"}, i_inst_addr, pc);
        check({tag, ".cnt"},  Fetch_Cnt, cnt);
        check({tag, ".exc"},  {27'd0, Exception_F}, flt ? 32'd4 : 32'd0);
        check({tag, ".inst"}, Instruction_F, flt ? 32'd0 : {16'hC0DE, pc[15:0]});
    endtask

    initial begin
        reset = 1'b0; En_F = 1'b1; req = 1'b0; eret_D = 1'b0;
        EPC = 32'd0; Jump_D = 1'b0; NPC_D = 32'd0; IsBJ_D = 1'b0;

        step(); step();
        check_state("reset", 32'h3000, 32'd0, 1'b0);
        check("reset.bd", {31'd0, BD_F}, 32'd0);

        reset = 1'b1;
        step(); check_state("seq1", 32'h3004, 32'd1, 1'b0);
        step(); check_state("seq2", 32'h3008, 32'd2, 1'b0);
        step(); step(); check_state("seq4", 32'h3010, 32'd4, 1'b0);

        Jump_D = 1'b1; NPC_D = 32'h3100; IsBJ_D = 1'b1;
        #1 check("jump.bd", {31'd0, BD_F}, 32'd1);
        step(); check_state("jump", 32'h3100, 32'd5, 1'b0);

        eret_D = 1'b1; EPC = 32'h3200; IsBJ_D = 1'b0;
        step(); check_state("eret_over_jump", 32'h3200, 32'd6, 1'b0);
        En_F = 1'b0;
        step(); check_state("stall", 32'h3200, 32'd6, 1'b0);
        step(); check_state("stall2", 32'h3200, 32'd6, 1'b0);
        En_F = 1'b1; eret_D = 1'b0;

        NPC_D = 32'h3002; IsBJ_D = 1'b1;
        step(); check_state("misalign", 32'h3002, 32'd7, 1'b1);
        check("misalign.bd", {31'd0, BD_F}, 32'd1);
        Jump_D = 1'b0; IsBJ_D = 1'b0;
        step(); check_state("fault_seq", 32'h3006, 32'd8, 1'b1);
        req = 1'b1;
        step(); check_state("req", 32'h4180, 32'd8, 1'b0);
        req = 1'b0;

        Jump_D = 1'b1; NPC_D = 32'h6FF8;
        step(); check_state("hi_m4", 32'h6FF8, 32'd9, 1'b0);
        Jump_D = 1'b0;
        step(); check_state("hi_edge", 32'h6FFC, 32'd10, 1'b0);
        step(); check_state("hi_over", 32'h7000, 32'd11, 1'b1);

        Jump_D = 1'b1; NPC_D = 32'h2FFC;
        step(); check_state("lo_under", 32'h2FFC, 32'd12, 1'b1);
        NPC_D = 32'hFFFF_FFFC;
        step(); check_state("top", 32'hFFFF_FFFC, 32'd13, 1'b1);
        Jump_D = 1'b0;
        step(); check_state("wrap", 32'h0000_0000, 32'd14, 1'b1);

        req = 1'b1; eret_D = 1'b1; EPC = 32'h3200; reset = 1'b0;
        step(); check_state("reset_over_req", 32'h3000, 32'd0, 1'b0);

        reset = 1'b1; eret_D = 1'b0; En_F = 1'b0;
        step(); check_state("req_in_stall", 32'h4180, 32'd0, 1'b0);
        req = 1'b0; En_F = 1'b1;
        step(); check_state("after_req", 32'h4184, 32'd1, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The port list SHALL be exactly the following, with clock and reset first:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- En_F  in  1  fetch advance enable; 1 = advance, 0 = stall/hold.
- req  in  1  exception/interrupt taken this cycle.
- eret_D  in  1  eret in D stage.
- EPC  in  32  return address for eret.
- Jump_D  in  1  branch/jump in D resolved taken.
- NPC_D  in  32  taken target from D.
- IsBJ_D  in  1  instruction in D is a branch/jump.
- i_inst_addr  out  32  instruction memory address, always equal to Pc_F.
- i_inst_rdata  in  32  instruction memory combinational read data.
- Pc_F  out  32  current fetch PC.
- Instruction_F  out  32  fetched instruction.
- Exception_F  out  5  fetch exception code.
- BD_F  out  1  fetched instruction sits in a delay slot.
- Fetch_Cnt  out  32  count of advancing fetch cycles.

Function
REQ-002 The block SHALL hold the PC in a 32-bit register, drive Pc_F from it and drive i_inst_addr from it.
REQ-003 Next-PC priority SHALL be: reset, then req, then hold when En_F=0, then eret_D, then Jump_D, then Pc_F+4.
REQ-004 When req=1, the PC SHALL load 32'h00004180 regardless of En_F, eret_D and Jump_D.
REQ-005 When En_F=1, eret_D=1 and req=0, the PC SHALL load EPC, and Jump_D SHALL be ignored.
REQ-006 When En_F=1, Jump_D=1, eret_D=0 and req=0, the PC SHALL load NPC_D.
REQ-007 When En_F=0 and req=0, the PC and Fetch_Cnt SHALL hold.
REQ-008 PC+4 SHALL use 32-bit modular arithmetic, so 32'hFFFFFFFC+4 wraps to 0.
REQ-009 An address fault SHALL be raised when Pc_F[1:0]!=0, when Pc_F<32'h00003000, or when Pc_F>32'h00006FFC; the check is combinational.
REQ-010 On an address fault, Exception_F SHALL be `AdEL and Instruction_F SHALL be 0; otherwise Exception_F SHALL be `Int and Instruction_F SHALL equal i_inst_rdata.
REQ-011 BD_F SHALL equal IsBJ_D combinationally, including on faulting fetches.
REQ-012 After a fault, the PC SHALL keep sequencing per REQ-003 and SHALL NOT self-redirect; only req redirects it.
REQ-013 Fetch_Cnt SHALL increment by 1 (wrapping modulo 2^32) in each cycle where reset=1, req=0 and En_F=1.
REQ-014 There SHALL be zero-cycle latency from Pc_F to Instruction_F, Exception_F and BD_F (combinational outputs).

Reset
REQ-015 While reset=0 at a posedge, the PC SHALL load 32'h00003000 and Fetch_Cnt SHALL load 0, overriding req, eret_D, Jump_D and En_F.
REQ-016 Reset asserted mid-stall or mid-redirect SHALL take effect on the next posedge, with no residual redirect carried over.
REQ-017 Immediately after reset, the outputs SHALL be Pc_F=32'h00003000, Exception_F=`Int, Instruction_F=i_inst_rdata, BD_F=IsBJ_D and Fetch_Cnt=0.

Structure
REQ-018 The shared constants.v SHALL hold `Int (5'd0), `AdEL (5'd4), the reset vector 32'h00003000, the handler vector 32'h00004180, and the text bounds 32'h00003000 and 32'h00006FFC.
REQ-019 The address check SHALL be one sub-module, fetch_addr_check (input Pc_F; outputs fault and Exception_F); next-PC selection and the registers SHALL stay in fetch_stage.

Verification
REQ-020 The bench SHALL cover: reset=0 for 2 cycles, then release with En_F=1 and no redirects -> Pc_F goes 3000, 3004, 3008 and Fetch_Cnt goes 0, 1, 2.
REQ-021 The bench SHALL cover: Pc_F=3010 with Jump_D=1, NPC_D=3100, IsBJ_D=1 -> BD_F=1 this cycle, Pc_F=3100 next cycle.
REQ-022 The bench SHALL cover: Jump_D=1 and eret_D=1 (EPC=3200) with En_F=1 -> Pc_F=3200 next cycle; the same stimulus with En_F=0 -> Pc_F holds and Fetch_Cnt holds.
REQ-023 The bench SHALL cover: NPC_D=3002 taken -> next cycle Exception_F=4 and Instruction_F=0; then req=1 -> Pc_F=4180 with Exception_F=0.
REQ-024 The bench SHALL cover: Pc_F=6FFC advancing -> next Pc_F=7000 with Exception_F=4.
REQ-025 The bench SHALL cover: req=1, eret_D=1 and reset=0 in the same cycle -> Pc_F=3000 and Fetch_Cnt=0.
